// File: rtl/vga_frame_ctrl.sv
// -----------------------------------------------------------------------------
// vga_frame_ctrl -- VGA timing generator and frame buffer fetch engine.
//
// Generates hsync/vsync/blank_n from a divided pixel tick and fetches the source
// image from the PPU frame buffer. Pixels are replicated SCALE times on both
// axes and centred at (X_OFF, Y_OFF). Colour is decoded through
// vga_color_decode and registered. Syncs and blank_n are delayed so that they
// line up with the colour.
//
// Optional feature macro: VGA_TEST_PATTERN_EN. When it is defined, the test_en
// input exists. While test_en is high, the colour stage shows 8 vertical bars
// in place of vga_data.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   vga_row_out/col_out    source row/column being fetched (held outside window)
//   vga_rd                 fetch strobe, one clk per pixel tick inside window
//   vga_data               palette index returned by the frame buffer
//   vga_done               high while the window is not being scanned
//   frame_start            one-clk pulse on the tick h=0, v=0
//   vga_clk                pixel clock, rises mid-pixel
//   hsync, vsync           active-low syncs
//   blank_n                high in the active area; sync_n tied high
//   R, G, B                registered colour
//   test_en                (VGA_TEST_PATTERN_EN only) select bar pattern
// -----------------------------------------------------------------------------

// Palette decode: 3-3-2 index expanded to 8 bits per channel by bit replication.
module vga_color_decode (
    input  logic [7:0] idx,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    assign r = {idx[7:5], idx[7:5], idx[7:6]};
    assign g = {idx[4:2], idx[4:2], idx[4:3]};
    assign b = {idx[1:0], idx[1:0], idx[1:0], idx[1:0]};
endmodule

module vga_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SRC_W    = 256,
    parameter int SRC_H    = 240,
    parameter int SCALE    = 2,
    parameter int X_OFF    = 64,
    parameter int Y_OFF    = 0,
    parameter int RD_LAT   = 1,
    parameter logic [7:0] BORDER = 8'h0F
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] vga_row_out,
    output logic [9:0] vga_col_out,
    output logic       vga_rd,
    input  logic [7:0] vga_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_en,
`endif
    output logic       vga_done,
    output logic       frame_start,
    output logic       vga_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       sync_n,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW = 12;
    localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LEN   = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LEN   = CW'(V_SYNC);
    localparam logic [CW-1:0] WX_BEG   = CW'(X_OFF);
    localparam logic [CW-1:0] WX_LEN   = CW'(SRC_W * SCALE);
    localparam logic [CW-1:0] WX_END   = CW'(X_OFF + SRC_W * SCALE);
    localparam logic [CW-1:0] WY_BEG   = CW'(Y_OFF);
    localparam logic [CW-1:0] WY_LEN   = CW'(SRC_H * SCALE);
    localparam logic [CW-1:0] WY_LAST  = CW'(Y_OFF + SRC_H * SCALE - 1);
    localparam logic [1:0]    SC_LAST  = 2'(SCALE - 1);
    localparam logic [9:0]    ROW_LAST = 10'(SRC_H - 1);

    generate
        if (SCALE < 1 || SCALE > 4 || CLK_DIV < 2 || RD_LAT < 0 || RD_LAT > 3 ||
            X_OFF + SRC_W * SCALE > H_ACTIVE || Y_OFF + SRC_H * SCALE > V_ACTIVE ||
            SRC_W > 1024 || SRC_H > 1024) begin : g_bad_params
            $error("vga_frame_ctrl: illegal parameter set");
        end
    endgenerate

    logic [DW-1:0] div, div_nxt;
    logic          tick;
    logic [CW-1:0] h, v;
    logic [CW-1:0] h_rel, v_rel, hs_rel, vs_rel;
    logic          win0, hs0, vs0, act0;
    logic [1:0]    sx, sx_nxt, sy;
    logic [9:0]    col_nxt, row_cnt;

    assign sync_n  = 1'b1;
    assign tick    = (div == DIV_LAST);
    assign div_nxt = tick ? '0 : div + 1'b1;

    // Range tests use wrapping subtraction: (x - base) < len is true only for
    // x in [base, base+len), and avoids a >= 0 compare when base is zero.
    assign h_rel  = h - WX_BEG;
    assign v_rel  = v - WY_BEG;
    assign hs_rel = h - HS_BEG;
    assign vs_rel = v - VS_BEG;
    assign win0   = (h_rel < WX_LEN) && (v_rel < WY_LEN);
    assign hs0    = !(hs_rel < HS_LEN);
    assign vs0    = !(vs_rel < VS_LEN);
    assign act0   = (h < H_ACT) && (v < V_ACT);

    // Column for the pixel fetched on this tick; sx is its position within
    // the SCALE-wide replication group.
    always_comb begin
        col_nxt = vga_col_out;
        sx_nxt  = sx;
        if (tick && win0) begin
            if (h == WX_BEG) begin
                col_nxt = '0;
                sx_nxt  = '0;
            end else if (sx == SC_LAST) begin
                col_nxt = vga_col_out + 10'd1;
                sx_nxt  = '0;
            end else begin
                sx_nxt = sx + 2'd1;
            end
        end
    end

    // Divider, raster counters and fetch side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            vga_clk     <= 1'b0;
            h           <= '0;
            v           <= '0;
            sx          <= '0;
            sy          <= '0;
            row_cnt     <= '0;
            vga_col_out <= '0;
            vga_row_out <= '0;
            vga_rd      <= 1'b0;
            frame_start <= 1'b0;
            vga_done    <= 1'b1;
        end else begin
            div         <= div_nxt;
            vga_clk     <= (div_nxt >= DIV_HALF);
            vga_rd      <= tick && win0;
            frame_start <= tick && (h == '0) && (v == '0);
            vga_col_out <= col_nxt;
            sx          <= sx_nxt;
            if (tick) begin
                if (win0) vga_row_out <= row_cnt;
                // vga_done rises one tick past the last window pixel and
                // falls on the first pixel of window row 0.
                if (h == WX_END && v == WY_LAST)      vga_done <= 1'b1;
                else if (h == WX_BEG && v == WY_BEG)  vga_done <= 1'b0;
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v       <= '0;
                        row_cnt <= '0;
                        sy      <= '0;
                    end else begin
                        v <= v + 1'b1;
                        if (v_rel < WY_LEN) begin
                            if (sy == SC_LAST) begin
                                sy <= '0;
                                if (row_cnt != ROW_LAST) row_cnt <= row_cnt + 10'd1;
                            end else begin
                                sy <= sy + 2'd1;
                            end
                        end
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    // Fetch/data contract: vga_rd is a one-clk strobe with vga_row_out and
    // vga_col_out valid alongside it. There is no back-pressure. vga_data must
    // hold the addressed index from RD_LAT ticks after the strobe until the
    // following tick edge, which is where it is sampled.
    logic [RD_LAT:0] hs_p, vs_p, act_p, win_p;
    logic [7:0]      data_idx, dec_idx, dec_r, dec_g, dec_b;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]      bar_p [RD_LAT:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p    <= '1;
            vs_p    <= '1;
            act_p   <= '0;
            win_p   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            R       <= '0;
            G       <= '0;
            B       <= '0;
`ifdef VGA_TEST_PATTERN_EN
            for (int i = 0; i <= RD_LAT; i++) bar_p[i] <= '0;
`endif
        end else if (tick) begin
            for (int i = RD_LAT; i > 0; i--) begin
                hs_p[i]  <= hs_p[i-1];
                vs_p[i]  <= vs_p[i-1];
                act_p[i] <= act_p[i-1];
                win_p[i] <= win_p[i-1];
`ifdef VGA_TEST_PATTERN_EN
                bar_p[i] <= bar_p[i-1];
`endif
            end
            hs_p[0]  <= hs0;
            vs_p[0]  <= vs0;
            act_p[0] <= act0;
            win_p[0] <= win0;
`ifdef VGA_TEST_PATTERN_EN
            bar_p[0] <= col_nxt[7:5];
`endif
            hsync   <= hs_p[RD_LAT];
            vsync   <= vs_p[RD_LAT];
            blank_n <= act_p[RD_LAT];
            R       <= act_p[RD_LAT] ? dec_r : 8'd0;
            G       <= act_p[RD_LAT] ? dec_g : 8'd0;
            B       <= act_p[RD_LAT] ? dec_b : 8'd0;
        end
    end

    always_comb begin
        data_idx = vga_data;
`ifdef VGA_TEST_PATTERN_EN
        if (test_en) data_idx = {2'b00, bar_p[RD_LAT], 3'b000};
`endif
        dec_idx = win_p[RD_LAT] ? data_idx : BORDER;
    end

    vga_color_decode u_decode (
        .idx (dec_idx),
        .r   (dec_r),
        .g   (dec_g),
        .b   (dec_b)
    );
endmodule
